// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-ported data memory (MEM stage + loader).
// Define ARB_ROUND_ROBIN_EN for round-robin conflicts; default is fixed port-0 priority.
module mem_arbiter #(
  parameter int MEM_BYTES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [63:0] addr0,
  input  logic [63:0] addr1,
  input  logic [63:0] wdata0,
  input  logic [63:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic        err0,
  output logic        err1,
  output logic [63:0] rdata0,
  output logic [63:0] rdata1,
  output logic [63:0] Mem_Addr,
  output logic [63:0] Write_Data,
  output logic        MemWrite,
  output logic        MemRead,
  input  logic [63:0] Read_Data
);

  typedef enum logic [1:0] {
    IDLE,
    SERVE,
    RESP
  } state_t;

  localparam logic [63:0] LIMIT = 64'(MEM_BYTES - 8);

  state_t      state_q;
  logic        port_q;
  logic        we_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic        ack0_q, ack1_q;
  logic        err0_q, err1_q;
  logic [63:0] rdata0_q, rdata1_q;

  logic        gnt_d;
  logic        in_range;
  logic        serve;

`ifdef ARB_ROUND_ROBIN_EN
  // prio_q names the port that wins the next conflict
  logic prio_q;

  always_comb begin
    gnt_d = (req0 && req1) ? prio_q : req1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q <= 1'b0;
    end else if (state_q == IDLE && (req0 || req1)) begin
      prio_q <= ~gnt_d;
    end
  end
`else
  always_comb begin
    gnt_d = ~req0;
  end
`endif

  assign in_range = (addr_q <= LIMIT);
  assign serve    = (state_q == SERVE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      port_q   <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      err0_q <= 1'b0;
      err1_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req0 || req1) begin
            port_q  <= gnt_d;
            we_q    <= gnt_d ? we1 : we0;
            addr_q  <= gnt_d ? addr1 : addr0;
            wdata_q <= gnt_d ? wdata1 : wdata0;
            state_q <= SERVE;
          end
        end
        SERVE: begin
          if (!we_q) begin
            if (port_q) rdata1_q <= in_range ? Read_Data : '0;
            else        rdata0_q <= in_range ? Read_Data : '0;
          end
          if (port_q) begin
            ack1_q <= 1'b1;
            err1_q <= ~in_range;
          end else begin
            ack0_q <= 1'b1;
            err0_q <= ~in_range;
          end
          state_q <= RESP;
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ack0       = ack0_q;
  assign ack1       = ack1_q;
  assign err0       = err0_q;
  assign err1       = err1_q;
  assign rdata0     = rdata0_q;
  assign rdata1     = rdata1_q;
  assign Mem_Addr   = serve ? addr_q : '0;
  assign Write_Data = serve ? wdata_q : '0;
  assign MemWrite   = serve && we_q && in_range;
  assign MemRead    = serve && !we_q && in_range;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: random and directed traffic against a
// byte-array reference; a negedge monitor checks every ack and bus cycle.
module tb_mem_arbiter;

  localparam int MB = 64;
  localparam logic [63:0] LIM = 64'(MB - 8);

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic        we0 = 1'b0, we1 = 1'b0;
  logic [63:0] addr0 = '0, addr1 = '0;
  logic [63:0] wdata0 = '0, wdata1 = '0;
  logic        ack0, ack1, err0, err1;
  logic [63:0] rdata0, rdata1;
  logic [63:0] Mem_Addr, Write_Data, Read_Data;
  logic        MemWrite, MemRead;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_BYTES(MB)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1),
    .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1),
    .err0(err0), .err1(err1),
    .rdata0(rdata0), .rdata1(rdata1),
    .Mem_Addr(Mem_Addr), .Write_Data(Write_Data),
    .MemWrite(MemWrite), .MemRead(MemRead),
    .Read_Data(Read_Data)
  );

  // Memory attached to the DUT bus
  logic [7:0] mem [MB];

  always_comb begin
    Read_Data = '0;
    if (Mem_Addr <= LIM)
      for (int i = 0; i < 8; i++)
        Read_Data[8*i +: 8] = mem[int'(Mem_Addr[5:0]) + i];
  end

  always @(posedge clk) begin
    if (MemWrite && Mem_Addr <= LIM)
      for (int i = 0; i < 8; i++)
        mem[int'(Mem_Addr[5:0]) + i] <= Write_Data[8*i +: 8];
  end

  // Reference model: a flat byte array updated in issue order
  logic [7:0] ref_mem [MB];

  function automatic logic [63:0] ref_rd(input logic [63:0] a);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = ref_mem[int'(a[5:0]) + i];
    return r;
  endfunction

  typedef struct packed {
    logic [31:0] due;
    logic        err;
    logic        rd;
    logic [63:0] data;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic [63:0] cur0 = '0, cur1 = '0;
  logic done = 1'b0, fin = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      cur0 = '0;
      cur1 = '0;
    end else begin
      chk("ack_exclusive", 64'(ack0 && ack1), 64'd0);
      if (ack0) begin
        if (q0.size() == 0) chk("ack0_unexpected", 64'd1, 64'd0);
        else begin
          e = q0.pop_front();
          chk("ack0_cycle", 64'(cyc), 64'(e.due));
          chk("err0", 64'(err0), 64'(e.err));
          if (e.rd) cur0 = e.data;
        end
      end else if (q0.size() > 0 && cyc >= int'(q0[0].due)) begin
        chk("ack0_missing", 64'd0, 64'd1);
        void'(q0.pop_front());
      end
      if (ack1) begin
        if (q1.size() == 0) chk("ack1_unexpected", 64'd1, 64'd0);
        else begin
          e = q1.pop_front();
          chk("ack1_cycle", 64'(cyc), 64'(e.due));
          chk("err1", 64'(err1), 64'(e.err));
          if (e.rd) cur1 = e.data;
        end
      end else if (q1.size() > 0 && cyc >= int'(q1[0].due)) begin
        chk("ack1_missing", 64'd0, 64'd1);
        void'(q1.pop_front());
      end
      chk("rdata0", rdata0, cur0);
      chk("rdata1", rdata1, cur1);
      if (MemWrite || MemRead) begin
        chk("strobe_exclusive", 64'(MemWrite && MemRead), 64'd0);
        chk("strobe_in_range", 64'(Mem_Addr > LIM), 64'd0);
      end else begin
        chk("bus_quiet", 64'(Mem_Addr != 0 && Mem_Addr <= LIM), 64'd0);
      end
      if (done && !fin) begin
        chk("queues_drained", 64'(q0.size() + q1.size()), 64'd0);
        fin = 1'b1;
      end
    end
  end

  task automatic drive(input int p, input logic r, input logic w,
                       input logic [63:0] a, input logic [63:0] d);
    if (p == 0) begin
      req0 = r; we0 = w; addr0 = a; wdata0 = d;
    end else begin
      req1 = r; we1 = w; addr1 = a; wdata1 = d;
    end
  endtask

  task automatic expect_txn(input int p, input logic w, input logic [63:0] a,
                            input logic [63:0] d, input int due);
    exp_t e;
    e.due  = 32'(due);
    e.err  = (a > LIM);
    e.rd   = !w;
    e.data = (!w && !e.err) ? ref_rd(a) : '0;
    if (w && !e.err)
      for (int i = 0; i < 8; i++) ref_mem[int'(a[5:0]) + i] = d[8*i +: 8];
    if (p == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Single transaction from idle; operands are scrambled once latched
  task automatic issue(input int p, input logic w, input logic [63:0] a, input logic [63:0] d);
    @(negedge clk);
    expect_txn(p, w, a, d, cyc + 2);
    drive(p, 1'b1, w, a, d);
    @(posedge clk); #1;
    drive(p, 1'b1, 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
    @(posedge clk); #1;
    drive(p, 1'b0, 1'b0, '0, '0);
    @(posedge clk);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    int c;
    int sel;
    logic [63:0] a;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 8; i++) issue(1, 1'b1, 64'(8 * i), {$urandom, $urandom});

    issue(0, 1'b1, 64'd8, 64'h1122334455667788);
    issue(0, 1'b0, 64'd8, '0);
    issue(1, 1'b0, 64'd57, '0);
    issue(1, 1'b0, 64'd56, '0);
    issue(0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, '0);
    issue(1, 1'b1, 64'd64, 64'hDEAD_BEEF_0000_0001);

    // Held request after ack becomes a new request three cycles later
    @(negedge clk);
    expect_txn(0, 1'b0, 64'd0, '0, cyc + 2);
    expect_txn(0, 1'b0, 64'd16, '0, cyc + 5);
    drive(0, 1'b1, 1'b0, 64'd0, '0);
    repeat (2) @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 64'd16, '0);
    repeat (3) @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, '0, '0);
    @(posedge clk);

    for (int n = 0; n < 60; n++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 8)       a = 64'($urandom_range(0, 56));
      else if (sel == 8) a = 64'($urandom_range(57, 300));
      else               a = {32'hFFFF_FFFF, $urandom};
      issue(int'($urandom_range(0, 1)), 1'($urandom), a, {$urandom, $urandom});
    end

    // Reset lands while a port-1 read is in SERVE
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 64'd16, '0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    expect_txn(1, 1'b0, 64'd16, '0, cyc + 2);
    repeat (2) @(posedge clk); #1;
    drive(1, 1'b0, 1'b0, '0, '0);
    @(posedge clk);

    // Both ports held for 12 cycles from a fresh reset
    reset_pulse();
    @(negedge clk);
    c = cyc;
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (i % 2 == 0) expect_txn(0, 1'b0, 64'd0, '0, c + 2 + 3 * i);
      else            expect_txn(1, 1'b0, 64'd8, '0, c + 2 + 3 * i);
`else
      expect_txn(0, 1'b0, 64'd0, '0, c + 2 + 3 * i);
`endif
    end
    drive(0, 1'b1, 1'b0, 64'd0, '0);
    drive(1, 1'b1, 1'b0, 64'd8, '0);
    repeat (12) @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    repeat (5) @(posedge clk);

    done = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_BYTES, default 64, byte capacity of the shared data memory.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0 / req1  input  1  access request, port 0 (pipeline MEM stage) / port 1 (loader).
REQ-005 we0 / we1  input  1  1 = write, 0 = read; valid while reqN high.
REQ-006 addr0 / addr1  input  64  byte address of 64-bit little-endian doubleword.
REQ-007 wdata0 / wdata1  input  64  write data.
REQ-008 ack0 / ack1  output  1  one-cycle completion pulse.
REQ-009 err0 / err1  output  1  out-of-range flag, valid with ackN.
REQ-010 rdata0 / rdata1  output  64  read data, registered per port.
REQ-011 Mem_Addr  output  64  address to data memory.
REQ-012 Write_Data  output  64  write data to data memory.
REQ-013 MemWrite / MemRead  output  1  memory strobes.
REQ-014 Read_Data  input  64  combinational read data from memory.

Function
REQ-015 FSM states IDLE, SERVE, RESP; one transaction per 3 cycles.
REQ-016 IDLE: if any reqN high at rising edge, SHALL pick winner, latch its we/addr/wdata and port id, go SERVE; else stay IDLE.
REQ-017 SERVE: Mem_Addr/Write_Data driven from latched values; MemWrite = latched we, MemRead = not latched we, both only if in range; next edge captures Read_Data into winner's rdataN, goes RESP.
REQ-018 RESP: ackN = 1 for winner only, errN = range result; next edge goes IDLE.
REQ-019 Outside SERVE, MemWrite = MemRead = 0, Mem_Addr = 0, Write_Data = 0.
REQ-020 Latency: req sampled at edge k -> strobes in cycle k+1 -> ack high in cycle k+2.
REQ-021 Requester SHALL hold reqN and operands stable until ackN; operand changes after latching are ignored.
REQ-022 reqN still high in the cycle after ackN counts as a new request.
REQ-023 In range iff addr <= MEM_BYTES-8 (unsigned, full 64 bits); otherwise no strobe, ack with err = 1, rdataN set to 0.
REQ-024 rdataN updates only on a completed read for port N; writes and the other port leave it unchanged.
REQ-025 ackN/errN SHALL never be high for both ports in the same cycle.
REQ-026 Simultaneous req0 and req1 in IDLE resolved per REQ-031/REQ-032; loser stays pending, no request dropped.

Reset
REQ-027 reset high at an edge SHALL force IDLE and clear latched operands, priority pointer (to port 0), ack0/1, err0/1, rdata0/1 to 0.
REQ-028 Reset during SERVE abandons the transaction: no ack issued; a write strobed in that SERVE cycle commits, as the memory samples on the same edge.
REQ-029 Reset during RESP suppresses ack in following cycles; requests held high across reset are re-arbitrated after reset deasserts.
REQ-030 Reset has priority over every other transition.

Configuration
REQ-031 Macro ARB_ROUND_ROBIN_EN defined: on conflict, port other than last-granted wins; pointer updates when entering SERVE.
REQ-032 Macro not defined: fixed priority, port 0 always wins conflicts; pointer logic absent.

Verification
REQ-033 Port 0 write addr=8, wdata=0x1122334455667788, then read addr=8 -> MemWrite one cycle, ack0 at k+2, rdata0=0x1122334455667788.
REQ-034 Port 1 read addr=57 (MEM_BYTES=64) -> no strobes, ack1 with err1=1, rdata1=0; addr=56 -> err1=0.
REQ-035 req0 and req1 held high together for 12 cycles -> with ARB_ROUND_ROBIN_EN grants alternate 0,1,0,1; without, port 0 granted every transaction, ack1 never.
REQ-036 reset asserted in SERVE of a port-1 read -> no ack1, rdata1=0, FSM IDLE next cycle, held req1 re-served after reset.
REQ-037 Back-to-back port-0 reads addr=0 then addr=16 -> acks exactly 3 cycles apart, rdata0 updated only at each ack.
